config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//   Feeds the CGRA configuration scan chain. Accepts configuration words over a valid/ready stream,
//   clears the chain, then serialises every word bit-by-bit into the first cell's serial input with
//   a per-bit shift enable, which gates the chain clock through an external ICG.
//   Sits between the host config interface and the head of the config-cell chain; asserts done once
//   exactly CHAIN_LEN bits have been shifted in.
// PARAMETERS
//   WORD_W      32    width of incoming configuration words
//   CHAIN_LEN   256   total bits in the config chain (sum of all cell sizes), >= 1
//   CLR_CYCLES  2     cycles cfg_chain_clr is held high before shifting, >= 1
//   CNT_W       $clog2(CHAIN_LEN+1)  derived localparam, width of bit counters
// PORTS
//   Config_Clock    in   1        single clock; all state updates on rising edge
//   Config_Reset_n  in   1        synchronous, active-low reset
//   start           in   1        pulse: begin a load; honoured only in IDLE or DONE
//   abort           in   1        pulse: stop the load and return to IDLE
//   word_data       in   WORD_W   configuration word
//   word_valid      in   1        word_data is valid
//   word_ready      out  1        loader accepts word_data this cycle
//   cfg_bit         out  1        serial data to the chain head's ConfigIn
//   cfg_shift_en    out  1        chain advances on the next Config_Clock edge (ICG enable)
//   cfg_chain_clr   out  1        active-high clear to the chain's Config_Reset
//   busy            out  1        high in CLEAR, WAIT_WORD and SHIFT
//   done            out  1        high in DONE: chain fully loaded
//   bits_loaded     out  CNT_W    bits shifted since the last start
// BEHAVIOUR
//   Reset (Config_Reset_n=0 at an edge): state=IDLE; all outputs 0; counters and word register 0.
//     Reset mid-load abandons the load immediately. The chain is not cleared until the next start.
//   FSM states: IDLE, CLEAR, WAIT_WORD, SHIFT, DONE.
//     IDLE/DONE + start -> CLEAR. On entry, clear bits_loaded and the clear counter; drop done.
//     CLEAR: cfg_chain_clr=1 for exactly CLR_CYCLES cycles -> WAIT_WORD.
//     WAIT_WORD: word_ready=1. On word_valid&&word_ready, latch word_data and go to SHIFT.
//     SHIFT: one bit per cycle, LSB first. cfg_bit=word_reg[0], cfg_shift_en=1. Word_reg shifts right.
//       bits_loaded increments by 1 each cycle.
//       Transitions after the last bit of a word: to DONE if bits_loaded reaches CHAIN_LEN,
//       otherwise to WAIT_WORD.
//       If CHAIN_LEN is reached mid-word, the remaining bits are discarded and the FSM goes to DONE.
//   Ordering: bit 0 of word 0 is shifted first and ends at the far tail of the chain. The last bit
//     shifted (bit CHAIN_LEN-1 overall) lands in the MSB of the head cell.
//   Throughput: WORD_W+1 cycles per full word (one accept cycle). word_ready=0 in every other state.
//   cfg_shift_en is 0 in all states except SHIFT; cfg_bit=0 whenever cfg_shift_en=0.
//   Words presented while word_ready=0 are not consumed; the source holds them (standard valid/ready).
//   start while busy is ignored. abort has priority over start and over every other transition:
//     next state IDLE, shift_en and ready drop next cycle, bits_loaded is held for debug.
//   Simultaneous start and word_valid in IDLE: start is taken; the word is not accepted until WAIT_WORD.
//   DONE persists until start, abort or reset. bits_loaded saturates at CHAIN_LEN and never wraps.
// STRUCTURE
//   Shared package config_loader_pkg:
//     - state enum cfg_ld_state_e
//     - localparam helpers for CNT_W and the word-count ceil(CHAIN_LEN/WORD_W)
//   One natural sub-module, cfg_piso: WORD_W-bit parallel-load, shift-right register
//     (load, shift, q0). The FSM and counters stay in config_chain_loader.
// TESTING
//   1. WORD_W=8, CHAIN_LEN=16; start; send words 0xA5 then 0x3C with valid held ->
//      clr high 2 cycles; cfg_bit sequence 1,0,1,0,0,1,0,1 | 0,0,1,1,1,1,0,0;
//      one ready cycle between words; done=1 after bit 16; bits_loaded=16.
//   2. CHAIN_LEN=12, WORD_W=8; words 0xFF, 0x0F ->
//      exactly 12 shift_en pulses, the last 4 bits of word 1 are dropped, word_ready=0 in DONE.
//   3. word_valid low for 5 cycles in WAIT_WORD ->
//      shift_en stays 0, bits_loaded is frozen, shifting resumes the cycle after the accept.
//   4. abort at bits_loaded=5 during SHIFT ->
//      next cycle IDLE, shift_en=0, busy=0, bits_loaded=5; a following start re-clears the chain
//      and counts from 0.
//   5. Config_Reset_n=0 for one edge mid-SHIFT ->
//      every output is 0 on the following cycle; start in the same cycle as reset is ignored.
//   6. start while busy, and start in DONE ->
//      the first is ignored (no clr pulse); the second restarts with a 2-cycle clr and done=0.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// ---------------------------------------------------------------------------
// config_loader_pkg
//   Shared types and helpers for the CGRA configuration chain loader.
//   - cfg_ld_state_e : loader FSM state encoding
//   - cnt_width()    : width of a counter that must hold 0..n inclusive
//   - word_count()   : number of WORD_W-bit words needed to fill the chain
// ---------------------------------------------------------------------------
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_WORD = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_DONE      = 3'd4
  } cfg_ld_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_CHAIN_LEN  = 256;
  localparam int DEF_CLR_CYCLES = 2;

  // Counter width able to represent every value 0..n (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // ceil(chain_len / word_w): words the host must supply for one full load.
  function automatic int word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_chain_loader_piso.sv
// ---------------------------------------------------------------------------
// cfg_piso
//   WORD_W-bit parallel-load, shift-right register. Bit 0 is presented on q0,
//   so a loaded word leaves LSB first. Zeros fill in from the top.
// Ports
//   Config_Clock    in  1       clock
//   Config_Reset_n  in  1       synchronous active-low reset (register -> 0)
//   load            in  1       capture d (wins over shift)
//   shift           in  1       shift right by one
//   d               in  WORD_W  parallel data
//   q0              out 1       current LSB
// ---------------------------------------------------------------------------
module cfg_piso #(
  parameter int WORD_W = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] d,
  output logic              q0
);

  logic [WORD_W-1:0] sr_reg;
  logic [WORD_W-1:0] sr_next;
  // One extra zero bit above the register so every stage reads a legal index.
  logic [WORD_W:0]   sr_ext;

  assign sr_ext = {1'b0, sr_reg};

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
    assign sr_next[gi] = load  ? d[gi]
                       : shift ? sr_ext[gi+1]
                       :         sr_reg[gi];
  end

  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset_n) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= sr_next;
    end
  end

  assign q0 = sr_reg[0];

endmodule

// File: rtl/config_chain_loader.sv
// ---------------------------------------------------------------------------
// config_chain_loader
//   Feeds the CGRA configuration scan chain. After start it pulses the chain
//   clear for CLR_CYCLES cycles, then takes configuration words over a
//   valid/ready stream and serialises them LSB first into the chain head,
//   one bit per cycle, with a shift enable that drives the chain's ICG.
//   done rises once exactly CHAIN_LEN bits have been shifted.
// Ports
//   Config_Clock    in   1       single clock, rising edge
//   Config_Reset_n  in   1       synchronous active-low reset
//   start           in   1       begin a load (honoured in IDLE/DONE only)
//   abort           in   1       stop the load, return to IDLE (top priority)
//   word_data       in   WORD_W  configuration word
//   word_valid      in   1       word_data valid
//   word_ready      out  1       word accepted this cycle when valid
//   cfg_bit         out  1       serial data to chain head ConfigIn
//   cfg_shift_en    out  1       chain advances on next clock edge
//   cfg_chain_clr   out  1       active-high chain clear
//   busy            out  1       CLEAR, WAIT_WORD or SHIFT
//   done            out  1       chain fully loaded
//   bits_loaded     out  CNT_W   bits shifted since last start
// ---------------------------------------------------------------------------
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter  int WORD_W     = DEF_WORD_W,
  parameter  int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter  int CLR_CYCLES = DEF_CLR_CYCLES,
  localparam int CNT_W      = cnt_width(CHAIN_LEN)
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_shift_en,
  output logic              cfg_chain_clr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_loaded
);

  localparam int CLR_W = cnt_width(CLR_CYCLES);
  localparam int BIT_W = cnt_width(WORD_W);

  cfg_ld_state_e    state_reg;
  cfg_ld_state_e    state_next;
  logic [CNT_W-1:0] bits_loaded_reg;
  logic [CLR_W-1:0] clr_cnt_reg;
  logic [BIT_W-1:0] bit_idx_reg;

  logic clr_last;
  logic word_last_bit;
  logic chain_last_bit;
  logic word_accept;
  logic piso_q0;

  assign clr_last       = (clr_cnt_reg == CLR_W'(CLR_CYCLES - 1));
  assign word_last_bit  = (bit_idx_reg == BIT_W'(WORD_W - 1));
  // The bit being shifted this cycle is the final chain bit.
  assign chain_last_bit = (bits_loaded_reg == CNT_W'(CHAIN_LEN - 1));
  // The handshake completes whenever ready and valid meet, even if abort is
  // also high: the source saw ready, so the word counts as consumed and is
  // simply dropped along with the rest of the load.
  assign word_accept    = (state_reg == ST_WAIT_WORD) && word_valid;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. abort overrides every other transition.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) state_next = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_last) state_next = ST_WAIT_WORD;
        end
        ST_WAIT_WORD: begin
          if (word_valid) state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          // Hitting CHAIN_LEN mid-word discards the rest of the word.
          if (chain_last_bit)     state_next = ST_DONE;
          else if (word_last_bit) state_next = ST_WAIT_WORD;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore: every output follows the registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    word_ready    = 1'b0;
    cfg_shift_en  = 1'b0;
    cfg_chain_clr = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        cfg_chain_clr = 1'b1;
        busy          = 1'b1;
      end
      ST_WAIT_WORD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_SHIFT: begin
        cfg_shift_en = 1'b1;
        busy         = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Keep the chain input quiet whenever it is not being clocked.
  assign cfg_bit     = cfg_shift_en & piso_q0;
  assign bits_loaded = bits_loaded_reg;

  // -------------------------------------------------------------------------
  // Counters. Frozen while abort is high so bits_loaded stays readable for
  // debug after an aborted load.
  // -------------------------------------------------------------------------
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset_n) begin
      bits_loaded_reg <= '0;
      clr_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
    end else if (!abort) begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            bits_loaded_reg <= '0;
            clr_cnt_reg     <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
        end
        ST_WAIT_WORD: begin
          if (word_valid) bit_idx_reg <= '0;
        end
        ST_SHIFT: begin
          // Saturate rather than wrap, even though the FSM leaves SHIFT first.
          if (bits_loaded_reg != CNT_W'(CHAIN_LEN)) begin
            bits_loaded_reg <= bits_loaded_reg + CNT_W'(1);
          end
          bit_idx_reg <= bit_idx_reg + BIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Word serialiser
  // -------------------------------------------------------------------------
  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .Config_Clock   (Config_Clock),
    .Config_Reset_n (Config_Reset_n),
    .load           (word_accept),
    .shift          (cfg_shift_en),
    .d              (word_data),
    .q0             (piso_q0)
  );

endmodule

// File: tb/tb_config_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_config_chain_loader
//   Random-word load sequences against a bit-stream reference model. The
//   expected chain stream (words LSB first, truncated to CHAIN_LEN) is queued
//   when a load is issued; a monitor pops one bit per shift_en cycle.
// ---------------------------------------------------------------------------
module tb_config_chain_loader;

  localparam int WORD_W     = 8;
  localparam int CHAIN_LEN  = 20;
  localparam int CLR_CYCLES = 2;
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              Config_Clock = 1'b0;
  logic              Config_Reset_n;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              cfg_bit;
  logic              cfg_shift_en;
  logic              cfg_chain_clr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bits_loaded;

  always #5 Config_Clock = ~Config_Clock;

  config_chain_loader #(
    .WORD_W     (WORD_W),
    .CHAIN_LEN  (CHAIN_LEN),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .Config_Clock   (Config_Clock),
    .Config_Reset_n (Config_Reset_n),
    .start          (start),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .cfg_bit        (cfg_bit),
    .cfg_shift_en   (cfg_shift_en),
    .cfg_chain_clr  (cfg_chain_clr),
    .busy           (busy),
    .done           (done),
    .bits_loaded    (bits_loaded)
  );

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;
  int load_no = 0;
  bit exp_q[$];
  bit mon_exp;
  logic [WORD_W-1:0] words [NWORDS];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the chain receives word 0 bit 0 first, then each word's
  // bits in ascending order, and stops after exactly CHAIN_LEN bits.
  task automatic queue_expected();
    int n;
    n = 0;
    exp_q.delete();
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < WORD_W; b++) begin
        if (n < CHAIN_LEN) exp_q.push_back(words[w][b]);
        n++;
      end
    end
  endtask

  task automatic random_words();
    for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
    queue_expected();
  endtask

  // Monitor: consumes one expected bit per shift cycle.
  always @(negedge Config_Clock) begin
    if (cfg_shift_en) begin
      shift_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_shift", 32'(exp_q.size()), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("cfg_bit", 32'(cfg_bit), int'(mon_exp));
      end
    end else begin
      chk("cfg_bit_idle", 32'(cfg_bit), 0);
    end
    chk("ready_vs_shift", 32'(word_ready & cfg_shift_en), 0);
  end

  // Called at a negedge. Issues start and measures the clear pulse.
  task automatic start_pulse(input bit with_valid);
    int n;
    shift_cnt = 0;
    start = 1'b1;
    if (with_valid) begin
      word_data  = words[0];
      word_valid = 1'b1;
    end
    @(negedge Config_Clock);
    start = 1'b0;
    chk("start_done_low", 32'(done), 0);
    chk("start_cnt_zero", 32'(bits_loaded), 0);
    chk("start_clr_high", 32'(cfg_chain_clr), 1);
    chk("start_no_ready", 32'(word_ready), 0);
    n = 0;
    while (cfg_chain_clr && n < 50) begin
      n++;
      @(negedge Config_Clock);
    end
    chk("clr_cycles", 32'(n), CLR_CYCLES);
    chk("wait_ready", 32'(word_ready), 1);
  endtask

  // Feeds words with random idle gaps; checks the WAIT_WORD freeze.
  task automatic send_words(input int max_gap);
    int gap;
    int n;
    for (int w = 0; w < NWORDS; w++) begin
      gap = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        if (word_ready) begin
          chk("wait_no_shift", 32'(cfg_shift_en), 0);
          chk("wait_frozen", 32'(bits_loaded), w * WORD_W);
        end
        @(negedge Config_Clock);
      end
      word_data  = words[w];
      word_valid = 1'b1;
      n = 0;
      while (!word_ready && n < 100) begin
        @(negedge Config_Clock);
        n++;
      end
      chk("ready_timeout", 32'(n < 100), 1);
      chk("accept_count", 32'(bits_loaded), w * WORD_W);
      @(posedge Config_Clock);
      #1;
      word_valid = 1'b0;
      word_data  = WORD_W'($urandom);
      @(negedge Config_Clock);
      chk("shift_resume", 32'(cfg_shift_en), 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge Config_Clock);
      n++;
    end
    chk("done", 32'(done), 1);
    chk("bits_final", 32'(bits_loaded), CHAIN_LEN);
    chk("shift_pulses", 32'(shift_cnt), CHAIN_LEN);
    chk("done_not_busy", 32'(busy), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    // A word offered in DONE must not be taken.
    word_valid = 1'b1;
    word_data  = WORD_W'($urandom);
    repeat (3) @(negedge Config_Clock);
    chk("done_no_ready", 32'(word_ready), 0);
    chk("done_holds", 32'(done), 1);
    chk("bits_no_wrap", 32'(bits_loaded), CHAIN_LEN);
    word_valid = 1'b0;
    $display("load %0d: words %0h %0h %0h shifted %0d bits done=%0b",
             load_no, words[0], words[1], words[2], shift_cnt, done);
    load_no++;
  endtask

  // Starts a load and runs it until bits_loaded reaches stop_at.
  task automatic load_until(input int stop_at);
    int n;
    random_words();
    start_pulse(1'b0);
    word_data  = words[0];
    word_valid = 1'b1;
    @(posedge Config_Clock);
    #1;
    word_valid = 1'b0;
    @(negedge Config_Clock);
    n = 0;
    while (bits_loaded != CNT_W'(stop_at) && n < 50) begin
      @(negedge Config_Clock);
      n++;
    end
    chk("reach_count", 32'(bits_loaded), stop_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Config_Reset_n = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    repeat (3) @(negedge Config_Clock);
    chk("rst_ready", 32'(word_ready), 0);
    chk("rst_shift", 32'(cfg_shift_en), 0);
    chk("rst_bit", 32'(cfg_bit), 0);
    chk("rst_clr", 32'(cfg_chain_clr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bits", 32'(bits_loaded), 0);
    Config_Reset_n = 1'b1;
    @(negedge Config_Clock);

    // Directed load, word valid offered together with start.
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h5A;
    queue_expected();
    start_pulse(1'b1);
    send_words(0);
    wait_done();

    // Random loads, each started from DONE; the first also tries start while busy.
    for (int l = 0; l < 4; l++) begin
      random_words();
      start_pulse(1'b0);
      if (l == 0) begin
        start = 1'b1;
        @(negedge Config_Clock);
        start = 1'b0;
        chk("busy_start_no_clr", 32'(cfg_chain_clr), 0);
        chk("busy_start_ready", 32'(word_ready), 1);
        chk("busy_start_cnt", 32'(bits_loaded), 0);
      end
      send_words(6);
      wait_done();
    end

    // Abort mid-shift at bits_loaded = 5.
    load_until(5);
    abort = 1'b1;
    @(negedge Config_Clock);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_shift", 32'(cfg_shift_en), 0);
    chk("abort_ready", 32'(word_ready), 0);
    chk("abort_bits", 32'(bits_loaded), 5);
    chk("abort_pulses", 32'(shift_cnt), 6);
    exp_q.delete();
    @(negedge Config_Clock);
    chk("abort_hold_bits", 32'(bits_loaded), 5);
    chk("abort_hold_done", 32'(done), 0);
    $display("abort at 5 bits: bits_loaded=%0d busy=%0b", bits_loaded, busy);

    // Restart from IDLE after the abort.
    random_words();
    start_pulse(1'b0);
    send_words(3);
    wait_done();

    // Reset mid-shift, with start asserted on the same edge.
    load_until(3);
    Config_Reset_n = 1'b0;
    start = 1'b1;
    @(negedge Config_Clock);
    Config_Reset_n = 1'b1;
    start = 1'b0;
    chk("mrst_ready", 32'(word_ready), 0);
    chk("mrst_shift", 32'(cfg_shift_en), 0);
    chk("mrst_bit", 32'(cfg_bit), 0);
    chk("mrst_clr", 32'(cfg_chain_clr), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_bits", 32'(bits_loaded), 0);
    exp_q.delete();
    repeat (2) @(negedge Config_Clock);
    chk("mrst_idle_busy", 32'(busy), 0);
    chk("mrst_idle_clr", 32'(cfg_chain_clr), 0);
    $display("reset mid-shift: busy=%0b bits_loaded=%0d", busy, bits_loaded);

    // Recovery load after reset.
    random_words();
    start_pulse(1'b0);
    send_words(2);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
